// File: rtl/odd_even_pkg.sv
// Shared constants and enums for the odd/even stream classifier.
// Optional counters are enabled with macro ODD_EVEN_STREAM_CNT_EN.
package odd_even_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        MODE_LSB    = 1'b0,
        MODE_PARITY = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/odd_even_classify.sv
// Combinational even/odd classifier for one data word.
// mode LSB: even when bit 0 is clear; mode PARITY: even popcount.
module odd_even_classify
    import odd_even_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic             is_even
);

    // Select the classification rule for the current mode
    always_comb begin
        is_even = 1'b0;
        unique case (mode_e'(mode))
            MODE_LSB:    is_even = ~data[0];
            MODE_PARITY: is_even = ~(^data);
            default:     is_even = 1'b0;
        endcase
    end

endmodule

// File: rtl/odd_even_stream.sv
// One-entry registered stream stage that tags each word even/odd.
// Delivery counters exist only when ODD_EVEN_STREAM_CNT_EN is defined.
module odd_even_stream
    import odd_even_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_even,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt
);

    state_e state;
    logic   cls_even;
    logic   in_hs;
    logic   out_hs;

    odd_even_classify #(
        .WIDTH(WIDTH)
    ) u_classify (
        .data   (in_data),
        .mode   (mode),
        .is_even(cls_even)
    );

    assign out_valid = (state == ST_FULL);
    assign in_ready  = (state == ST_EMPTY) || out_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Holding register: a new capture always wins over draining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            out_data    <= '0;
            out_is_even <= 1'b0;
        end else if (in_hs) begin
            state       <= ST_FULL;
            out_data    <= in_data;
            out_is_even <= cls_even;
        end else if (out_hs) begin
            state       <= ST_EMPTY;
        end
    end

`ifdef ODD_EVEN_STREAM_CNT_EN

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating delivery counters; clear has priority over counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            even_cnt <= '0;
            odd_cnt  <= '0;
        end else if (clr) begin
            even_cnt <= '0;
            odd_cnt  <= '0;
        end else if (out_hs) begin
            if (out_is_even) begin
                if (even_cnt != CNT_MAX)
                    even_cnt <= even_cnt + 1'b1;
            end else begin
                if (odd_cnt != CNT_MAX)
                    odd_cnt <= odd_cnt + 1'b1;
            end
        end
    end

`else

    logic unused_clr;

    assign unused_clr = clr;
    assign even_cnt   = '0;
    assign odd_cnt    = '0;

`endif

endmodule
